muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the register file read ports, consuming rdat1/rdat2 as operands.
- Its result and destination register feed the register file write port (wdat/wsel/wen) through writeback.
- One operation in flight; ready/valid handshakes on both sides.

---
 rtl/rv32ima_pkg.sv | 44 ++++
 rtl/muldiv_if.sv | 29 ++
 rtl/muldiv_core.sv | 59 +++++
 rtl/muldiv_unit.sv | 130 +++++++++++++
 tb/tb_muldiv_unit.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32ima_pkg.sv
// Shared RV32IMA types and constants; this slice adds the multiply/divide unit encodings.
package rv32ima_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned MULDIV_LATENCY = WORD_W + 1;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [4:0]        reg_t;

    // RV32M funct3 encoding
    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } muldiv_state_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input muldiv_op_t op);
        return op[2] && op[1];
    endfunction

    function automatic logic rs1_signed(input muldiv_op_t op);
        return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic rs2_signed(input muldiv_op_t op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Handshake bundle between issue logic, the multiply/divide unit and writeback.
interface muldiv_if #(
    parameter int XLEN = 32
) (
    input logic clk,
    input logic nrst
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_in;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport unit (
        input  clk, nrst, in_valid, op, rs1_data, rs2_data, rd_in, flush, out_ready,
        output in_ready, out_valid, result, rd_out
    );

    modport tb (
        input  clk, nrst, in_ready, out_valid, result, rd_out,
        output in_valid, op, rs1_data, rs2_data, rd_in, flush, out_ready
    );
endinterface

// File: rtl/muldiv_core.sv
// Iterative datapath: 2*XLEN accumulator, one shift-add or restoring shift-subtract per step.
module muldiv_core
    import rv32ima_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] acc_step,
    output logic              last
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   b_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   hi, lo;
    logic [XLEN:0]     sum, rem_sh, diff;

    always_comb begin
        hi     = acc_q[2*XLEN-1:XLEN];
        lo     = acc_q[XLEN-1:0];
        sum    = {1'b0, hi} + {1'b0, b_q};
        rem_sh = {hi, lo[XLEN-1]};
        diff   = rem_sh - {1'b0, b_q};
        if (is_div) begin
            // Keep the trial subtraction only when it does not borrow.
            if (!diff[XLEN]) acc_step = {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
            else             acc_step = {rem_sh[XLEN-1:0], lo[XLEN-2:0], 1'b0};
        end else begin
            if (lo[0]) acc_step = {sum, lo[XLEN-1:1]};
            else       acc_step = {1'b0, hi, lo[XLEN-1:1]};
        end
    end

    assign last = (cnt_q == LAST_CNT);

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            acc_q <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else if (start) begin
            acc_q <= {{XLEN{1'b0}}, a};
            b_q   <= b;
            cnt_q <= '0;
        end else if (step) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: FSM, handshakes, special cases and sign fix-up around muldiv_core.
module muldiv_unit
    import rv32ima_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t     state_q, state_d;
    muldiv_op_t        op_in, op_q;
    logic [XLEN-1:0]   mag_a, mag_b, mag_a_q, mag_b_q;
    logic [XLEN-1:0]   special_val, result_q, fix, sel;
    logic [2*XLEN-1:0] acc_step, prod;
    logic              accept, neg_a, neg_b, neg_in, neg_q, init_q;
    logic              div_zero, div_ovf, special, start, step, last, core_div;
    reg_t              rd_q;

    assign op_in = muldiv_op_t'(op);

    always_comb begin
        accept   = in_valid && (state_q == IDLE) && !flush;
        neg_a    = rs1_signed(op_in) && rs1_data[XLEN-1];
        neg_b    = rs2_signed(op_in) && rs2_data[XLEN-1];
        mag_a    = neg_a ? -rs1_data : rs1_data;
        mag_b    = neg_b ? -rs2_data : rs2_data;
        neg_in   = op_is_rem(op_in) ? neg_a : (neg_a ^ neg_b);
        div_zero = op_is_div(op_in) && (rs2_data == '0);
        div_ovf  = ((op_in == DIV) || (op_in == REM)) && (rs1_data == MIN_NEG) && (rs2_data == '1);
        special  = div_zero || div_ovf;
        if (div_zero) special_val = op_is_rem(op_in) ? rs1_data : '1;
        else          special_val = op_is_rem(op_in) ? '0 : MIN_NEG;
    end

    // Fix-up uses the core's final step value so the result is registered on entry to DONE.
    always_comb begin
        prod = neg_q ? -acc_step : acc_step;
        sel  = op_is_rem(op_q) ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
        if (op_is_div(op_q)) fix = neg_q ? -sel : sel;
        else if (op_q == MUL) fix = prod[XLEN-1:0];
        else                  fix = prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = special ? DONE : CALC;
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (init_q) begin
                    start = 1'b1;
                end else begin
                    step = 1'b1;
                    if (last) state_d = DONE;
                end
            end
            DONE: begin
                if (flush || out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q  <= IDLE;
            op_q     <= MUL;
            neg_q    <= 1'b0;
            init_q   <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= accept && !special;
            if (accept) begin
                op_q    <= op_in;
                neg_q   <= neg_in;
                mag_a_q <= mag_a;
                mag_b_q <= mag_b;
                rd_q    <= rd_in;
                if (special) result_q <= special_val;
            end
            if (step && last) result_q <= fix;
        end
    end

    assign core_div = op_is_div(op_q);

    muldiv_core #(
        .XLEN (XLEN),
        .CNT_W(CNT_W)
    ) u_core (
        .clk     (clk),
        .nrst    (nrst),
        .start   (start),
        .step    (step),
        .is_div  (core_div),
        .a       (mag_a_q),
        .b       (mag_b_q),
        .acc_step(acc_step),
        .last    (last)
    );

    assign in_ready  = (state_q == IDLE) && !nrst;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign rd_out    = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed table-driven bench for muldiv_unit plus hand-written flush/reset/backpressure sequences.
module tb_muldiv_unit;
    import rv32ima_pkg::*;

    logic clk = 1'b0;
    logic nrst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    muldiv_if #(.XLEN(32)) bus (.clk(clk), .nrst(nrst));

    muldiv_unit #(
        .XLEN (32),
        .CNT_W(6)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .in_valid (bus.in_valid),
        .in_ready (bus.in_ready),
        .op       (bus.op),
        .rs1_data (bus.rs1_data),
        .rs2_data (bus.rs2_data),
        .rd_in    (bus.rd_in),
        .flush    (bus.flush),
        .out_valid(bus.out_valid),
        .out_ready(bus.out_ready),
        .result   (bus.result),
        .rd_out   (bus.rd_out)
    );

    typedef struct {
        muldiv_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        chk("in_ready before accept", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.rd_in    = rd;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op       = 3'($urandom);
        bus.rs1_data = $urandom;
        bus.rs2_data = $urandom;
        bus.rd_in    = 5'($urandom);
    endtask

    // Ends on the negedge where out_valid is first seen (or the bound expires).
    task automatic wait_out(output int lat, output logic seen, output logic ir_seen);
        lat = 0;
        seen = 1'b0;
        ir_seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
            if (bus.in_ready) ir_seen = 1'b1;
        end
    endtask

    task automatic finish_op(input string name, input logic [31:0] exp, input logic [4:0] rd,
                             input int exp_lat, input int hold);
        int   lat;
        logic seen, ir_seen, unstable;
        wait_out(lat, seen, ir_seen);
        chk({name, " out_valid"}, 32'(seen), 32'd1);
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " result"}, bus.result, exp);
        chk({name, " rd_out"}, 32'(bus.rd_out), 32'(rd));
        chk({name, " in_ready while busy"}, 32'(ir_seen), 32'd0);
        if (hold > 0) begin
            unstable = 1'b0;
            bus.in_valid = 1'b1;
            bus.op       = MUL;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (bus.result !== exp || bus.rd_out !== rd || !bus.out_valid || bus.in_ready)
                    unstable = 1'b1;
            end
            bus.in_valid = 1'b0;
            chk({name, " stable under backpressure"}, 32'(unstable), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk({name, " out_valid after handshake"}, 32'(bus.out_valid), 32'd0);
        chk({name, " in_ready after handshake"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        logic hit = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.out_valid) hit = 1'b1;
        end
        chk({name, " no spurious out_valid"}, 32'(hit), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        logic seen, ir_seen;
        vecs.push_back('{MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33});
        vecs.push_back('{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
        vecs.push_back('{MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33});
        vecs.push_back('{MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33});
        vecs.push_back('{MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33});
        vecs.push_back('{MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33});
        vecs.push_back('{MULH,   32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 33});
        vecs.push_back('{MUL,    32'h00000000, 32'h00000005, 32'h00000000, 33});
        vecs.push_back('{DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33});
        vecs.push_back('{REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33});
        vecs.push_back('{DIVU,   32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 33});
        vecs.push_back('{REMU,   32'hFFFFFFF9, 32'h00000002, 32'h00000001, 33});
        vecs.push_back('{DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33});
        vecs.push_back('{REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33});
        vecs.push_back('{DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, 33});
        vecs.push_back('{REMU,   32'h00000064, 32'h00000007, 32'h00000002, 33});
        vecs.push_back('{DIVU,   32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1});
        vecs.push_back('{REM,    32'h00001234, 32'h00000000, 32'h00001234, 1});
        vecs.push_back('{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});

        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.rs1_data  = '0;
        bus.rs2_data  = '0;
        bus.rd_in     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset in_ready", 32'(bus.in_ready), 32'd0);
        chk("reset result", bus.result, 32'd0);
        chk("reset rd_out", 32'(bus.rd_out), 32'd0);
        nrst = 1'b0;
        @(negedge clk);
        chk("in_ready after reset", 32'(bus.in_ready), 32'd1);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i));
            finish_op($sformatf("vec%0d", i), vecs[i].exp, 5'(i), vecs[i].lat, 0);
        end

        // Backpressure with a competing request held on in_valid
        issue(DIV, 32'hFFFFFFF9, 32'h00000002, 5'd9);
        finish_op("backpressure", 32'hFFFFFFFD, 5'd9, 33, 10);
        issue(MULHU, 32'h00010000, 32'h00010000, 5'd10);
        finish_op("after backpressure", 32'h00000001, 5'd10, 33, 0);

        // Flush in CALC
        issue(MUL, 32'd9, 32'd9, 5'd3);
        repeat (5) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush calc out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush calc in_ready", 32'(bus.in_ready), 32'd1);
        expect_quiet("flush calc", 40);
        issue(MUL, 32'd3, 32'd4, 5'd4);
        finish_op("mul after flush", 32'd12, 5'd4, 33, 0);

        // Flush in IDLE drops the simultaneous request
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        bus.op       = DIVU;
        bus.rs1_data = 32'd5;
        bus.rs2_data = 32'd0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        @(negedge clk);
        chk("flush idle in_ready", 32'(bus.in_ready), 32'd1);
        expect_quiet("flush idle", 40);

        // Flush in DONE
        issue(DIVU, 32'h00001234, 32'h00000000, 5'd7);
        wait_out(lat, seen, ir_seen);
        chk("done before flush", 32'(seen), 32'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush done out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush done in_ready", 32'(bus.in_ready), 32'd1);

        // Asynchronous reset mid-CALC
        issue(MUL, 32'd5, 32'd5, 5'd11);
        repeat (10) @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("async reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("async reset result", bus.result, 32'd0);
        chk("async reset rd_out", 32'(bus.rd_out), 32'd0);
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        chk("in_ready after mid reset", 32'(bus.in_ready), 32'd1);
        expect_quiet("mid reset", 40);
        issue(DIV, 32'd100, 32'hFFFFFFF6, 5'd12);
        finish_op("div after reset", 32'hFFFFFFF6, 5'd12, 33, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
